// File: rtl/toy_dmem_arbiter.sv
// toy_dmem_arbiter: two-port arbiter serialising m0/m1 accesses onto a single-port 64x32 memory.
// Define TOY_ARB_FIXED_PRIO_EN for fixed priority (m0 wins every conflict); default is round-robin.
module toy_dmem_arbiter #(
    parameter int AW = 6,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          reset_n_i,
    input  logic          m0_req_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [DW-1:0] m0_wdata_i,
    input  logic          m1_req_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [DW-1:0] m1_wdata_i,
    output logic          m0_gnt_o,
    output logic          m1_gnt_o,
    output logic          m0_rvalid_o,
    output logic          m1_rvalid_o,
    output logic [DW-1:0] m0_rdata_o,
    output logic [DW-1:0] m1_rdata_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          busy_o,
    output logic [7:0]    conflict_cnt_o
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e        state_q, state_d;
    logic          we_q, we_d, owner_q, owner_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          m0_gnt_q, m0_gnt_d, m1_gnt_q, m1_gnt_d;
    logic          m0_rvalid_q, m0_rvalid_d, m1_rvalid_q, m1_rvalid_d;
    logic [DW-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          any_req, both_req, win;

    assign any_req  = m0_req_i | m1_req_i;
    assign both_req = m0_req_i & m1_req_i;

`ifdef TOY_ARB_FIXED_PRIO_EN
    assign win = ~m0_req_i;
`else
    logic last_q, last_d;
    // win = 1 selects m1; on a conflict the requester that did not own the last grant wins
    assign win    = both_req ? ~last_q : m1_req_i;
    assign last_d = (state_q == IDLE && any_req) ? win : last_q;
    always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i) last_q <= 1'b1;
        else            last_q <= last_d;
`endif

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        owner_d     = owner_q;
        m0_gnt_d    = 1'b0;
        m1_gnt_d    = 1'b0;
        m0_rvalid_d = 1'b0;
        m1_rvalid_d = 1'b0;
        m0_rdata_d  = m0_rdata_q;
        m1_rdata_d  = m1_rdata_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    we_d     = win ? m1_we_i    : m0_we_i;
                    addr_d   = win ? m1_addr_i  : m0_addr_i;
                    wdata_d  = win ? m1_wdata_i : m0_wdata_i;
                    owner_d  = win;
                    m0_gnt_d = ~win;
                    m1_gnt_d = win;
                    state_d  = ACCESS;
                end
                if (both_req && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
            end
            ACCESS: state_d = we_q ? IDLE : RESP;
            RESP: begin
                m0_rvalid_d = ~owner_q;
                m1_rvalid_d = owner_q;
                m0_rdata_d  = owner_q ? m0_rdata_q : mem_rdata_i;
                m1_rdata_d  = owner_q ? mem_rdata_i : m1_rdata_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            owner_q     <= 1'b0;
            m0_gnt_q    <= 1'b0;
            m1_gnt_q    <= 1'b0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            owner_q     <= owner_d;
            m0_gnt_q    <= m0_gnt_d;
            m1_gnt_q    <= m1_gnt_d;
            m0_rvalid_q <= m0_rvalid_d;
            m1_rvalid_q <= m1_rvalid_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
            cnt_q       <= cnt_d;
        end
    end

    assign mem_en_o       = (state_q == ACCESS);
    assign mem_we_o       = mem_en_o & we_q;
    assign mem_addr_o     = addr_q;
    assign mem_wdata_o    = wdata_q;
    assign busy_o         = (state_q != IDLE);
    assign m0_gnt_o       = m0_gnt_q;
    assign m1_gnt_o       = m1_gnt_q;
    assign m0_rvalid_o    = m0_rvalid_q;
    assign m1_rvalid_o    = m1_rvalid_q;
    assign m0_rdata_o     = m0_rdata_q;
    assign m1_rdata_o     = m1_rdata_q;
    assign conflict_cnt_o = cnt_q;
endmodule

// File: tb/tb_toy_dmem_arbiter.sv
// tb_toy_dmem_arbiter: directed checks of toy_dmem_arbiter against a behavioural memory.
module tb_toy_dmem_arbiter;
    localparam int AW = 6;
    localparam int DW = 32;
`ifdef TOY_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic          clk = 1'b0, reset_n = 1'b0;
    logic          m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_en, mem_we, busy;
    logic [DW-1:0] m0_rdata, m1_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [7:0]    conflict_cnt;
    logic [DW-1:0] mem [64];
    int            tests = 0, fails = 0;

    toy_dmem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m0_gnt_o(m0_gnt), .m1_gnt_o(m1_gnt), .m0_rvalid_o(m0_rvalid), .m1_rvalid_o(m1_rvalid),
        .m0_rdata_o(m0_rdata), .m1_rdata_o(m1_rdata),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .busy_o(busy), .conflict_cnt_o(conflict_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA5A5_0000 + i;
        mem_rdata = '0;
    end

    always @(posedge clk)
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_gnt", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_en}, 0);
        chk("rst_rdata", m0_rdata | m1_rdata, 0);
        chk("rst_cnt", conflict_cnt, 0);
        reset_n = 1;

        // m0 write 0xDEADBEEF to addr 5
        @(negedge clk);
        m0_req = 1; m0_we = 1; m0_addr = 5; m0_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("wr_gnt", {m0_gnt, m1_gnt, mem_en, mem_we, busy}, 5'b10111);
        chk("wr_addr", mem_addr, 5);
        chk("wr_wdata", mem_wdata, 32'hDEADBEEF);
        m0_req = 0;
        @(negedge clk);
        chk("wr_done", {busy, mem_en, m0_gnt}, 0);

        // m1 read addr 5
        m1_req = 1; m1_we = 0; m1_addr = 5;
        @(negedge clk);
        chk("rd_gnt", {m0_gnt, m1_gnt, mem_en, mem_we}, 4'b0110);
        m1_req = 0;
        @(negedge clk);
        chk("rd_resp", {busy, m1_rvalid, mem_en}, 3'b100);
        @(negedge clk);
        chk("rd_valid", {m1_rvalid, m0_rvalid, busy}, 3'b100);
        chk("rd_data", m1_rdata, 32'hDEADBEEF);
        chk("rd_m0_untouched", m0_rdata, 0);
        @(negedge clk);
        chk("rd_pulse", m1_rvalid, 0);
        chk("rd_hold", m1_rdata, 32'hDEADBEEF);

        // m1 write/read top address 63, then addr 0 must be unaffected
        m1_req = 1; m1_we = 1; m1_addr = 63; m1_wdata = 32'h12345678;
        @(negedge clk);
        chk("w63_addr", {mem_we, mem_addr}, {1'b1, 6'd63});
        m1_req = 0;
        @(negedge clk);
        m1_req = 1; m1_we = 0;
        @(negedge clk);
        m1_req = 0;
        @(negedge clk);
        @(negedge clk);
        chk("r63_data", {m1_rvalid, m1_rdata}, {1'b1, 32'h12345678});
        m1_req = 1; m1_addr = 0;
        @(negedge clk);
        m1_req = 0;
        @(negedge clk);
        @(negedge clk);
        chk("r0_noalias", m1_rdata, 32'hA5A5_0000);
        chk("cnt_zero", conflict_cnt, 0);

        // both request reads continuously
        m0_req = 1; m0_we = 0; m0_addr = 1;
        m1_req = 1; m1_we = 0; m1_addr = 2;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("rr_gnt%0d", k), {m0_gnt, m1_gnt},
                (FIXED || k % 2 == 0) ? 2'b10 : 2'b01);
            chk($sformatf("rr_cnt%0d", k), conflict_cnt, k + 1);
            @(negedge clk);
            @(negedge clk);
            chk($sformatf("rr_rdata%0d", k),
                (FIXED || k % 2 == 0) ? {m0_rvalid, m0_rdata} : {m1_rvalid, m1_rdata},
                (FIXED || k % 2 == 0) ? {1'b1, 32'hA5A5_0001} : {1'b1, 32'hA5A5_0002});
        end
        repeat (300 * 3) @(negedge clk);
        chk("cnt_sat", conflict_cnt, 255);
        m0_req = 0; m1_req = 0;
        repeat (4) @(negedge clk);
        chk("cnt_sat_hold", conflict_cnt, 255);

        // reset during RESP of an m0 read
        m0_req = 1; m0_addr = 3;
        @(negedge clk);
        chk("rs_gnt", m0_gnt, 1);
        m0_req = 0;
        @(negedge clk);
        chk("rs_in_resp", busy, 1);
        reset_n = 0;
        #1;
        chk("rs_async", {busy, mem_en, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}, 0);
        chk("rs_cnt", conflict_cnt, 0);
        chk("rs_rdata", m0_rdata | m1_rdata, 0);
        @(negedge clk);
        reset_n = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rs_no_rvalid%0d", k), {m0_rvalid, busy}, 0);
        end
        m0_req = 1; m1_req = 1;
        @(negedge clk);
        chk("rs_first_conflict", {m0_gnt, m1_gnt}, 2'b10);
        chk("rs_first_cnt", conflict_cnt, 1);
        m0_req = 0; m1_req = 0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/toy_dmem_arbiter.md
# toy_dmem_arbiter

Two-port arbiter that shares the single-port toy data memory (64 × 32-bit words) between the processor load/store port (m0) and a loader/debug port (m1). It serialises requests through a small FSM. Access ordering is round-robin, and each access has a fixed, deterministic latency. The arbiter sits between the requesters and the memory array, and is the only agent that drives the memory enable and write strobes.

## Interface
- AW, 6, word-address width (64 words; addresses wrap modulo 2^AW)
- DW, 32, data width
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- m0_req / m1_req  in  1  access request; held until grant
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  AW  word address
- m0_wdata / m1_wdata  in  DW  write data
- m0_gnt / m1_gnt  out  1  one-cycle grant pulse; request fields have been captured
- m0_rvalid / m1_rvalid  out  1  one-cycle read-data-valid pulse
- m0_rdata / m1_rdata  out  DW  read data; holds its last value until the next read completes
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write strobe; only meaningful when mem_en = 1
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  synchronous read data, valid the cycle after mem_en
- busy  out  1  high whenever the FSM is not in IDLE
- conflict_cnt  out  8  saturating count of arbitration conflicts

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high at the clock edge, pick a winner.
  - Latch the winner's we, addr and wdata into internal registers.
  - Set gnt of the winner for the next cycle, then go to ACCESS.
- ACCESS:
  - mem_en = 1.
  - mem_we, mem_addr and mem_wdata are driven from the latched fields.
  - Next state: IDLE for a write, RESP for a read.
- RESP:
  - At the edge, capture mem_rdata into the winner's rdata register.
  - Pulse that requester's rvalid for one cycle, then go to IDLE.
- The loser's request is not dropped. It stays pending and is evaluated again in the next IDLE cycle.
- Round-robin rule:
  - A 1-bit last_owner register is updated on every grant.
  - When both requesters are active, grant the one that is not last_owner.
  - last_owner resets to 1, so m0 wins the first conflict.
- conflict_cnt increments when both req are high at an IDLE sampling edge. It saturates at 255.
- Requester rules:
  - Keep req, we, addr and wdata stable until gnt is seen.
  - Deassert req in the gnt cycle, or a new request is taken at the next IDLE edge.
  - Fields may change freely after gnt.
- mem_en, mem_we and busy decode combinationally from the state and latched registers. All other outputs are registered.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State → IDLE.
  - All gnt, rvalid and mem_en = 0.
  - rdata registers = 0, conflict_cnt = 0, last_owner = 1.
- Reset mid-operation:
  - In-flight access is aborted.
  - mem_en drops immediately.
  - No rvalid is issued afterwards.
- Write sequence (E0 = sampling edge in IDLE):
  - gnt and mem_en high in cycle E0+1.
  - Memory is written at E1.
  - Arbiter is back in IDLE after E1 and can sample again at E2.
  - Throughput: 1 write per 2 cycles.
- Read sequence:
  - gnt and mem_en high in cycle E0+1.
  - RESP is cycle E1+1.
  - rvalid and rdata valid in cycle E2+1, which is 3 cycles after the sampling edge.
  - The next sampling edge is E3.
  - Throughput: 1 read per 3 cycles.
- gnt and mem_en are asserted in exactly the same cycle.
- gnt is never high for both requesters at once.
- Address arithmetic uses AW bits only. Address 63 is the top word; there is no out-of-range error.

## Configuration
- TOY_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority. m0 always wins a conflict, and last_owner is neither implemented nor used. conflict_cnt still counts.
  - Undefined (default): round-robin as described in Operation.

## Test plan
- Single m0 write, addr = 5, wdata = 0xDEADBEEF, m1 idle:
  - m0_gnt and mem_en = 1 with mem_we = 1 and mem_addr = 5 one cycle after the sampling edge.
  - busy returns to 0 after 2 cycles.
- m1 read of addr 5 after that write:
  - m1_rvalid pulses 3 cycles after the sampling edge.
  - m1_rdata = 0xDEADBEEF.
  - m0_rvalid stays 0.
- m0 and m1 both request reads continuously from reset:
  - Grant order is m0, m1, m0, m1.
  - conflict_cnt increments on each IDLE sampling edge.
  - With TOY_ARB_FIXED_PRIO_EN defined, m0 is granted every time and m1 starves.
- 300 back-to-back conflicting requests: conflict_cnt saturates at 255 and does not wrap.
- reset_n asserted during RESP of an m0 read:
  - All outputs go to 0 asynchronously.
  - No m0_rvalid appears after release.
  - The first conflict after release is granted to m0.
- m1 write to addr 63, then a read of addr 63: the same data returns, with no aliasing to addr 0.
